// File: rtl/str_match_pkg.sv
// Shared definitions for the programmable string sequence matcher:
// character-class bit positions, FSM state encoding and config clamping.
package str_match_pkg;

    localparam int NCLS = 14;

    localparam int START_STOP  = 0;
    localparam int VOWEL       = 1;
    localparam int CONSONANT   = 2;
    localparam int UPPER       = 3;
    localparam int NUMBER      = 4;
    localparam int PUNCT_BASIC = 5;
    localparam int PUNCT_EXT   = 6;
    localparam int SPACE       = 7;
    localparam int TAB         = 8;
    localparam int NEWLINE     = 9;
    localparam int HEX_ALPHA   = 10;
    localparam int SIGN        = 11;
    localparam int UNDERSCORE  = 12;
    localparam int OTHER       = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_RUN   = 3'd2,
        ST_SKIP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // A zero minimum would let a segment be skipped entirely; store it as 1.
    function automatic int unsigned clamp_min(input int unsigned mn);
        return (mn == 0) ? 1 : mn;
    endfunction

    function automatic int unsigned clamp_max(input int unsigned mx, input int unsigned mn);
        return (mx < mn) ? mn : mx;
    endfunction

    function automatic int unsigned clamp_nseg(input int unsigned n, input int unsigned max_seg);
        if (n == 0) return 1;
        if (n > max_seg) return max_seg;
        return n;
    endfunction

endpackage

// File: rtl/str_seg_table.sv
// Pattern register file: MAX_SEG entries of class mask plus min/max repeat,
// and the active segment count. Writes are clamped; reads entries i and i+1.
module str_seg_table
    import str_match_pkg::*;
#(
    parameter int MAX_SEG = 4,
    parameter int CNT_W   = 4,
    parameter int NCLS    = str_match_pkg::NCLS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       cfg_we,
    input  logic [$clog2(MAX_SEG)-1:0] cfg_idx,
    input  logic [NCLS-1:0]            cfg_mask,
    input  logic [CNT_W-1:0]           cfg_min,
    input  logic [CNT_W-1:0]           cfg_max,
    input  logic                       cfg_nseg_we,
    input  logic [$clog2(MAX_SEG):0]   cfg_nseg,
    input  logic [$clog2(MAX_SEG)-1:0] rd_idx,
    output logic [NCLS-1:0]            mask_a,
    output logic [CNT_W-1:0]           min_a,
    output logic [CNT_W-1:0]           max_a,
    output logic [NCLS-1:0]            mask_b,
    output logic [$clog2(MAX_SEG):0]   nseg
);

    localparam int SEG_W  = $clog2(MAX_SEG);
    localparam int NSEG_W = SEG_W + 1;

    logic [NCLS-1:0]   mask_q [MAX_SEG];
    logic [CNT_W-1:0]  min_q  [MAX_SEG];
    logic [CNT_W-1:0]  max_q  [MAX_SEG];
    logic [NSEG_W-1:0] nseg_q;

    logic [CNT_W-1:0]  wr_min;
    logic [CNT_W-1:0]  wr_max;
    logic [NSEG_W-1:0] wr_nseg;
    logic [SEG_W-1:0]  rd_idx_b;

    always_comb begin
        wr_min  = CNT_W'(clamp_min(32'(cfg_min)));
        wr_max  = CNT_W'(clamp_max(32'(cfg_max), 32'(wr_min)));
        wr_nseg = NSEG_W'(clamp_nseg(32'(cfg_nseg), MAX_SEG));
    end

    // Bit 0 (start_stop) is cleared on write so a terminator never matches a segment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_SEG; k++) begin
                mask_q[k] <= '0;
                min_q[k]  <= CNT_W'(1);
                max_q[k]  <= CNT_W'(1);
            end
            nseg_q <= NSEG_W'(1);
        end else begin
            if (wr_en && cfg_we) begin
                mask_q[cfg_idx] <= cfg_mask & ~NCLS'(1);
                min_q[cfg_idx]  <= wr_min;
                max_q[cfg_idx]  <= wr_max;
            end
            if (wr_en && cfg_nseg_we) begin
                nseg_q <= wr_nseg;
            end
        end
    end

    // Entry i+1 wraps at the top index; the matcher only uses it when i < nseg-1.
    assign rd_idx_b = rd_idx + SEG_W'(1);
    assign mask_a   = mask_q[rd_idx];
    assign min_a    = min_q[rd_idx];
    assign max_a    = max_q[rd_idx];
    assign mask_b   = mask_q[rd_idx_b];
    assign nseg     = nseg_q;

endmodule

// File: rtl/str_seq_matcher.sv
// Programmable segment/repeat string recogniser over pre-classified characters.
// Optional verdict statistics (n_acc/n_rej) under STR_SEQ_MATCHER_STATS_EN.
module str_seq_matcher #(
    parameter int MAX_SEG = 4,
    parameter int CNT_W   = 4,
    parameter int NCLS    = str_match_pkg::NCLS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid,
    input  logic [NCLS-1:0]            cls,
    input  logic                       cfg_we,
    input  logic [$clog2(MAX_SEG)-1:0] cfg_idx,
    input  logic [NCLS-1:0]            cfg_mask,
    input  logic [CNT_W-1:0]           cfg_min,
    input  logic [CNT_W-1:0]           cfg_max,
    input  logic                       cfg_nseg_we,
    input  logic [$clog2(MAX_SEG):0]   cfg_nseg,
    output logic                       busy,
    output logic                       res_valid,
    output logic                       res_match,
`ifdef STR_SEQ_MATCHER_STATS_EN
    output logic [15:0]                n_acc,
    output logic [15:0]                n_rej,
`endif
    output logic [$clog2(MAX_SEG)-1:0] res_seg
);

    import str_match_pkg::*;

    localparam int SEG_W  = $clog2(MAX_SEG);
    localparam int NSEG_W = SEG_W + 1;

    state_t            state_q, state_d;
    logic [SEG_W-1:0]  i_q, i_d;
    logic [CNT_W-1:0]  c_q, c_d;
    logic              match_q, match_d;
    logic [SEG_W-1:0]  seg_q, seg_d;

    logic [NCLS-1:0]   mask_a, mask_b;
    logic [CNT_W-1:0]  min_a, max_a;
    logic [NSEG_W-1:0] nseg;

    logic is_ss, hit_cur, hit_nxt, has_next, is_last, min_ok, room;

    str_seg_table #(
        .MAX_SEG (MAX_SEG),
        .CNT_W   (CNT_W),
        .NCLS    (NCLS)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (state_q == ST_IDLE),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_mask    (cfg_mask),
        .cfg_min     (cfg_min),
        .cfg_max     (cfg_max),
        .cfg_nseg_we (cfg_nseg_we),
        .cfg_nseg    (cfg_nseg),
        .rd_idx      (i_q),
        .mask_a      (mask_a),
        .min_a       (min_a),
        .max_a       (max_a),
        .mask_b      (mask_b),
        .nseg        (nseg)
    );

    assign is_ss    = cls[START_STOP];
    assign hit_cur  = |(cls & mask_a);
    assign hit_nxt  = |(cls & mask_b);
    assign has_next = ({1'b0, i_q} + NSEG_W'(1)) < nseg;
    assign is_last  = {1'b0, i_q} == (nseg - NSEG_W'(1));
    assign min_ok   = c_q >= min_a;
    assign room     = c_q < max_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            c_q     <= '0;
            match_q <= 1'b0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            c_q     <= c_d;
            match_q <= match_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        c_d     = c_q;
        match_d = match_q;
        seg_d   = seg_q;
        case (state_q)
            ST_IDLE: begin
                if (valid && is_ss) begin
                    state_d = ST_FIRST;
                    i_d     = '0;
                    c_d     = '0;
                end
            end
            ST_FIRST: begin
                if (valid) begin
                    if (hit_cur) begin
                        state_d = ST_RUN;
                        i_d     = '0;
                        c_d     = CNT_W'(1);
                    end else begin
                        // Empty string rejects now; a stray first character waits for its \0.
                        state_d = is_ss ? ST_DONE : ST_SKIP;
                        match_d = 1'b0;
                        seg_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (valid) begin
                    // Greedy: another repeat of seg i beats advancing to seg i+1.
                    if (hit_cur && room) begin
                        c_d = c_q + CNT_W'(1);
                    end else if (min_ok && has_next && hit_nxt) begin
                        i_d = i_q + SEG_W'(1);
                        c_d = CNT_W'(1);
                    end else if (is_ss && min_ok && is_last) begin
                        state_d = ST_DONE;
                        match_d = 1'b1;
                        seg_d   = '0;
                    end else begin
                        state_d = is_ss ? ST_DONE : ST_SKIP;
                        match_d = 1'b0;
                        seg_d   = i_q;
                    end
                end
            end
            ST_SKIP: begin
                if (valid && is_ss) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ST_FIRST) || (state_q == ST_RUN) || (state_q == ST_SKIP);
    assign res_valid = (state_q == ST_DONE);
    assign res_match = match_q;
    assign res_seg   = seg_q;

`ifdef STR_SEQ_MATCHER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_acc <= '0;
            n_rej <= '0;
        end else if (state_q == ST_DONE) begin
            if (match_q) begin
                if (n_acc != 16'hFFFF) n_acc <= n_acc + 16'd1;
            end else begin
                if (n_rej != 16'hFFFF) n_rej <= n_rej + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_str_seq_matcher.sv
// Bench for str_seq_matcher: directed scenarios plus randomized patterns/strings
// checked against a run-length reference model of the segment rules.
module tb_str_seq_matcher;
  import str_match_pkg::*;

  localparam int MAX_SEG = 4;
  localparam int CNT_W   = 4;
  localparam int SEG_W   = 2;
  localparam int NSEG_W  = 3;

  localparam logic [NCLS-1:0] C_SS = NCLS'(1) << START_STOP;
  localparam logic [NCLS-1:0] C_V  = NCLS'(1) << VOWEL;
  localparam logic [NCLS-1:0] C_P  = NCLS'(1) << PUNCT_BASIC;
  localparam logic [NCLS-1:0] C_N  = NCLS'(1) << NUMBER;

  // verdict encoding {match, seg}
  localparam logic [SEG_W:0] ACC  = 3'b100;
  localparam logic [SEG_W:0] REJ0 = 3'b000;
  localparam logic [SEG_W:0] REJ1 = 3'b001;
  localparam logic [SEG_W:0] REJ2 = 3'b010;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic [NCLS-1:0]   cls;
  logic              cfg_we;
  logic [SEG_W-1:0]  cfg_idx;
  logic [NCLS-1:0]   cfg_mask;
  logic [CNT_W-1:0]  cfg_min, cfg_max;
  logic              cfg_nseg_we;
  logic [NSEG_W-1:0] cfg_nseg;
  logic              busy, res_valid, res_match;
  logic [SEG_W-1:0]  res_seg;
`ifdef STR_SEQ_MATCHER_STATS_EN
  logic [15:0]       n_acc, n_rej;
`endif

  str_seq_matcher #(.MAX_SEG(MAX_SEG), .CNT_W(CNT_W), .NCLS(NCLS)) dut (
    .clk(clk), .rst(rst), .valid(valid), .cls(cls),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_nseg_we(cfg_nseg_we), .cfg_nseg(cfg_nseg),
    .busy(busy), .res_valid(res_valid), .res_match(res_match),
`ifdef STR_SEQ_MATCHER_STATS_EN
    .n_acc(n_acc), .n_rej(n_rej),
`endif
    .res_seg(res_seg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [NCLS-1:0] m_mask [MAX_SEG];
  int              m_min  [MAX_SEG];
  int              m_max  [MAX_SEG];
  int              m_nseg;
  logic [NCLS-1:0] str_q [$];
  logic [SEG_W:0]  exp_q [$];
  logic [SEG_W:0]  last_vd;
  logic [SEG_W:0]  mon_v;
  int              acc_cnt, rej_cnt;
  int              checks = 0;
  int              errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < MAX_SEG; s++) begin
      m_mask[s] = '0;
      m_min[s]  = 1;
      m_max[s]  = 1;
    end
    m_nseg  = 1;
    acc_cnt = 0;
    rej_cnt = 0;
  endfunction

  function automatic logic [NCLS-1:0] ch(input int b);
    return NCLS'(1) << b;
  endfunction

  function automatic bit hits(input logic [NCLS-1:0] c, input int s);
    return (c & m_mask[s] & ~NCLS'(1)) != '0;
  endfunction

  // Each segment greedily eats up to max matching characters; it must reach min,
  // and whatever follows must open the next segment or be the terminator after the last.
  function automatic logic [SEG_W:0] model_verdict();
    int pos;
    int k;
    pos = 0;
    for (int s = 0; s < m_nseg; s++) begin
      k = 0;
      while (pos < str_q.size() && k < m_max[s] && hits(str_q[pos], s)) begin
        k++;
        pos++;
      end
      if (k < m_min[s]) return {1'b0, SEG_W'(s)};
      if (s == m_nseg - 1) begin
        if (pos == str_q.size()) return ACC;
        return {1'b0, SEG_W'(s)};
      end
      if (pos == str_q.size() || !hits(str_q[pos], s + 1)) return {1'b0, SEG_W'(s)};
    end
    return REJ0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [NCLS-1:0] c, input int gap);
    repeat (gap) begin
      valid = 1'b0;
      cls   = NCLS'($urandom);
      tick();
    end
    valid = 1'b1;
    cls   = c;
    tick();
    valid = 1'b0;
    cls   = '0;
  endtask

  task automatic cfg_write(input bit we, input int idx, input logic [NCLS-1:0] mask,
                           input int mn, input int mx, input bit nwe, input int n,
                           input bit apply);
    int cmn;
    cfg_we      = we;
    cfg_idx     = SEG_W'(idx);
    cfg_mask    = mask;
    cfg_min     = CNT_W'(mn);
    cfg_max     = CNT_W'(mx);
    cfg_nseg_we = nwe;
    cfg_nseg    = NSEG_W'(n);
    tick();
    cfg_we      = 1'b0;
    cfg_nseg_we = 1'b0;
    if (apply) begin
      if (we) begin
        cmn         = (mn == 0) ? 1 : mn;
        m_mask[idx] = mask;
        m_min[idx]  = cmn;
        m_max[idx]  = (mx < cmn) ? cmn : mx;
      end
      if (nwe) m_nseg = (n == 0) ? 1 : ((n > MAX_SEG) ? MAX_SEG : n);
    end
  endtask

  task automatic set_common();
    cfg_write(1, 0, C_V, 1, 3, 1, 3, 1);
    cfg_write(1, 1, C_P, 1, 1, 0, 0, 1);
    cfg_write(1, 2, C_N, 1, 2, 0, 0, 1);
  endtask

  // Frames str_q with \0 on both sides; cfg_at >= 0 attempts a (dropped) config
  // write while the string is in flight.
  task automatic run_string(input int max_gap, input bit overlap, input int cfg_at);
    logic [SEG_W:0] v;
    v = model_verdict();
    exp_q.push_back(v);
    if (v[SEG_W]) acc_cnt++; else rej_cnt++;
    last_vd = '1;
    send_char(C_SS, $urandom_range(max_gap, 0));
    check("busy_open", 32'(busy), 32'(1));
    foreach (str_q[k]) begin
      if (k == cfg_at)
        cfg_write(1, $urandom_range(MAX_SEG - 1, 0), NCLS'($urandom) & ~NCLS'(1),
                  $urandom_range(7, 0), $urandom_range(7, 0), 1, $urandom_range(4, 1), 0);
      send_char(str_q[k], $urandom_range(max_gap, 0));
      check("busy_mid", 32'(busy), 32'(1));
    end
    send_char(C_SS, $urandom_range(max_gap, 0));
    check("verdict_latency", 32'(res_valid), 32'(1));
    check("busy_done", 32'(busy), 32'(0));
    if (overlap) begin
      valid = 1'b1;
      cls   = C_SS;
    end
    tick();
    valid = 1'b0;
    cls   = '0;
    check("pulse_width", 32'(res_valid), 32'(0));
    check("no_reopen", 32'(busy), 32'(0));
  endtask

  function automatic logic [NCLS-1:0] pick(input logic [NCLS-1:0] m);
    int b;
    for (int t = 0; t < 40; t++) begin
      b = $urandom_range(NCLS - 1, 1);
      if (m[b]) return ch(b);
    end
    for (int j = 1; j < NCLS; j++) if (m[j]) return ch(j);
    return ch(OTHER);
  endfunction

  function automatic void gen_string();
    int lo, hi, reps;
    str_q.delete();
    if ($urandom_range(9, 0) == 0) return;
    for (int s = 0; s < m_nseg; s++) begin
      lo   = (s == 0) ? 1 : m_min[s] - 1;
      hi   = m_max[s] + 1;
      reps = $urandom_range(hi, lo);
      repeat (reps) str_q.push_back(pick(m_mask[s]));
    end
    if (str_q.size() > 1 && $urandom_range(3, 0) == 0)
      str_q[$urandom_range(str_q.size() - 1, 1)] = ch($urandom_range(NCLS - 1, 1));
    if (str_q.size() > 1 && $urandom_range(5, 0) == 0)
      void'(str_q.pop_back());
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_verdict: observed res_valid with %0d pending expected", exp_q.size());
      end else begin
        mon_v   = exp_q.pop_front();
        last_vd = {res_match, res_seg};
        check("verdict", 32'({res_match, res_seg}), 32'(mon_v));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NCLS-1:0] m;
    rst = 1'b1; valid = 1'b0; cls = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_mask = '0; cfg_min = '0; cfg_max = '0;
    cfg_nseg_we = 1'b0; cfg_nseg = '0;
    last_vd = '0;
    model_reset();
    tick(); tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_res_match", 32'(res_match), 32'(0));
    check("rst_res_seg", 32'(res_seg), 32'(0));
    rst = 1'b0;
    tick();

    // Directed strings on the common pattern.
    set_common();
    str_q = '{C_V, C_V, C_P, C_N};
    run_string(0, 0, -1);
    check("ae.7_accept", 32'(last_vd), 32'(ACC));
    str_q = '{C_V, C_V, C_V, C_V, C_P, C_N};
    run_string(0, 0, -1);
    check("aeio.7_reject", 32'(last_vd), 32'(REJ0));
    str_q = '{C_V, C_P, C_N, C_N, C_N};
    run_string(0, 0, -1);
    check("a.123_reject", 32'(last_vd), 32'(REJ2));
    str_q = '{C_V, C_V, C_P, C_N};
    run_string(1, 1, -1);
    check("ae.7_stalled", 32'(last_vd), 32'(ACC));
    str_q = '{C_V, C_P, C_N, C_N};
    run_string(0, 0, -1);
    check("a.77_accept", 32'(last_vd), 32'(ACC));
`ifdef STR_SEQ_MATCHER_STATS_EN
    check("stats_acc3", 32'(n_acc), 32'(3));
    check("stats_rej2", 32'(n_rej), 32'(2));
`endif
    str_q = '{C_V, C_P};
    run_string(0, 0, -1);
    check("a._early_term", 32'(last_vd), 32'(REJ1));

    // Config write while busy must be dropped.
    str_q = '{C_V, C_V, C_P, C_N};
    run_string(0, 0, 1);
    check("cfg_busy_dropped", 32'(last_vd), 32'(ACC));
    str_q = '{C_V, C_P, C_N};
    run_string(0, 0, -1);
    check("cfg_busy_table", 32'(last_vd), 32'(ACC));

    // Asynchronous reset mid-string: no verdict, busy drops at once, table resets.
    send_char(C_SS, 0);
    send_char(C_V, 0);
    send_char(C_V, 0);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_res_valid", 32'(res_valid), 32'(0));
    tick(); tick();
    rst = 1'b0;
    model_reset();
    tick();
    str_q.delete();
    run_string(0, 0, -1);
    check("empty_reject", 32'(last_vd), 32'(REJ0));
    cfg_write(1, 0, C_V, 1, 1, 1, 2, 1);
    str_q = '{C_V, C_P};
    run_string(0, 0, -1);
    check("table_was_reset", 32'(last_vd), 32'(REJ0));

    // Clamping of config fields.
    cfg_write(1, 0, C_V, 0, 0, 1, 1, 1);
    str_q = '{C_V};
    run_string(0, 0, -1);
    check("clamp_min0_acc", 32'(last_vd), 32'(ACC));
    str_q = '{C_V, C_V};
    run_string(0, 0, -1);
    check("clamp_max0_rej", 32'(last_vd), 32'(REJ0));
    cfg_write(1, 0, C_V, 3, 1, 1, 0, 1);
    str_q = '{C_V, C_V, C_V};
    run_string(0, 0, -1);
    check("clamp_max_lt_min", 32'(last_vd), 32'(ACC));
    str_q = '{C_V, C_V};
    run_string(0, 0, -1);
    check("clamp_min3_rej", 32'(last_vd), 32'(REJ0));

    // Randomized patterns and strings against the reference model.
    for (int p = 0; p < 10; p++) begin
      for (int s = 0; s < MAX_SEG; s++) begin
        m = '0;
        repeat ($urandom_range(3, 1)) m |= ch($urandom_range(NCLS - 1, 1));
        cfg_write(1, s, m, $urandom_range(3, 0), $urandom_range(5, 0),
                  s == MAX_SEG - 1, $urandom_range(7, 0), 1);
      end
      for (int n = 0; n < 20; n++) begin
        gen_string();
        run_string($urandom_range(2, 0), $urandom_range(1, 0),
                   ($urandom_range(7, 0) == 0) ? 0 : -1);
      end
    end

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
`ifdef STR_SEQ_MATCHER_STATS_EN
    check("stats_n_acc", 32'(n_acc), 32'(acc_cnt));
    check("stats_n_rej", 32'(n_rej), 32'(rej_cnt));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/str_seq_matcher.md
# str_seq_matcher

Programmable successor of the fixed per-variant string recogniser. It checks a stream of pre-classified characters against a run-time-loaded pattern of up to MAX_SEG segments. Each segment is a character-class mask plus a min/max repeat count. Strings are framed by start_stop (\0) on both sides, and each string produces one accept/reject verdict. The block sits after the character classifier and in place of the per-variant tsk FSM.

## Interface
- MAX_SEG, 4: maximum pattern segments; must be ≥ 2.
- CNT_W, 4: repeat-counter width; max repeat is 2^CNT_W−1.
- NCLS, 14: class-vector width; bit order is fixed by the package.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid  in  1  a character is presented this cycle.
- cls  in  NCLS  one-hot-or-more class flags of the character; bit 0 = start_stop.
- cfg_we  in  1  write segment entry cfg_idx.
- cfg_idx  in  $clog2(MAX_SEG)  segment index.
- cfg_mask  in  NCLS  classes accepted by the segment; bit 0 is ignored.
- cfg_min, cfg_max  in  CNT_W  repeat bounds.
- cfg_nseg_we  in  1  write the active segment count.
- cfg_nseg  in  $clog2(MAX_SEG)+1  number of active segments.
- busy  out  1  high from opening \0 until the verdict is issued.
- res_valid  out  1  one-cycle verdict pulse.
- res_match  out  1  1 = accepted; qualified by res_valid.
- res_seg  out  $clog2(MAX_SEG)  segment where rejection occurred; 0 on accept.

## Operation
- States: IDLE, FIRST, RUN, SKIP, DONE. Registers: seg index i, repeat count c.
- A character "matches segment j" when (cls & mask[j]) ≠ 0.
- IDLE: on valid & \0, go to FIRST and raise busy.
- FIRST: on valid, if the character matches seg0, go to RUN with i=0, c=1. Otherwise reject with res_seg=0; a \0 here (empty string) is also a reject.
- RUN, on valid, evaluated in this priority order:
  - Matches seg i and c < max[i]: stay, c+1. Greedy rule: staying wins over advancing.
  - c ≥ min[i], i < nseg−1, and the character matches seg i+1: i+1, c=1.
  - \0, c ≥ min[i], and i = nseg−1: accept.
  - \0 otherwise: reject, res_seg=i. The \0 is consumed as the terminator.
  - Any other character: go to SKIP, latching res_seg=i.
- SKIP: ignore characters until valid & \0, then reject with the latched res_seg.
- Accept or reject goes to DONE. DONE drives the res_valid pulse and drops busy, then returns to IDLE. The next string needs its own opening \0.
- Config writes take effect only in IDLE. Writes in any other state are dropped.
- Config write clamping:
  - min=0 is stored as 1.
  - max<min is stored as max=min.
  - nseg=0 or nseg>MAX_SEG is stored as clamped to 1 or MAX_SEG.
- Counter c never wraps. Because c increments only while c < max, it stays at or below max.

## Timing
- Reset values:
  - State IDLE, i=0, c=0.
  - busy=0, res_valid=0, res_match=0, res_seg=0.
  - All masks 0, min=max=1, nseg=1.
- Stall handling: one evaluation per valid cycle; cycles with valid=0 hold all state.
- Verdict latency: res_valid rises on the cycle after the terminating \0 is sampled (via DONE). It stays high for exactly one cycle.
- Verdict and input overlap: valid during DONE is ignored, so a \0 arriving on that cycle does not open a new string.
- Reset mid-string: asynchronous return to reset values, with no verdict issued. The pattern table is also reset.
- Simultaneous cfg_we and cfg_nseg_we are both applied.

## Configuration
- STR_SEQ_MATCHER_STATS_EN defined: adds outputs n_acc and n_rej, 16 bits each. They are saturating counters of verdicts, reset to 0, and increment on the res_valid cycle.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package str_match_pkg:
  - Class bit indices (START_STOP=0 … OTHER=13), plus NCLS.
  - State enum.
  - Clamping function for the config fields.
- Sub-module str_seg_table: the MAX_SEG-entry mask/min/max register file with write clamping and a dual combinational read for entries i and i+1. The FSM stays in the top.

## Test plan
Common pattern for the first four scenarios: seg0 = vowel, 1..3; seg1 = punctuation_basic, 1..1; seg2 = number, 1..2; nseg=3.
- \0 "ae." "7" \0 (i.e. \0 a e . 7 \0) -> res_valid one cycle after final \0, res_match=1, res_seg=0.
- \0 "aeio.7" \0 -> 4th vowel is the fourth repeat and does not match seg1, so reject; res_match=0, res_seg=0, busy held through SKIP until \0.
- \0 "a.123" \0 -> reject, res_seg=2. \0 "a." \0 -> early-terminator reject, res_seg=1.
- valid toggling 1/0 every cycle during \0 "ae.7" \0 -> same accept, verdict delayed only by the stalls; rst pulsed mid-string -> no res_valid, busy=0 immediately.
- cfg_we with cfg_min=0, cfg_max=0 in IDLE -> readback min=max=1. cfg_we while busy -> table unchanged.
- With STR_SEQ_MATCHER_STATS_EN: 3 accepts and 2 rejects -> n_acc=3, n_rej=2.
